rom_uart_rx_subsystem: RTL and testbench

Byte-stream source and serial receiver for the UART loopback path. A fixed-message ROM and its address sequencer feed bytes to an external transmitter, advancing on the transmitter's per-byte handshake. An independent 8N1 UART receiver decodes the serial line back into bytes. All logic sits in one clock domain, with the receiver input synchronized internally.

---
 rtl/rom_uart_rx_subsystem.sv | 201 ++++++++++++++++++++
 tb/tb_rom_uart_rx_subsystem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_uart_rx_subsystem.sv
// rom_uart_rx_subsystem
// Fixed-message ROM with a handshake-driven address sequencer, plus an
// independent 8N1 UART receiver with a 2-flop input synchronizer.
module rom_uart_rx_subsystem #(
  parameter int CLK_FREQ   = 1036800,
  parameter int BAUDRATE   = 115200,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_addr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] transmit_data,
  output logic                  is_data,
  input  logic                  tx_line,
  output logic [DATA_WIDTH-1:0] receive_data,
  output logic                  is_receiving,
  output logic                  is_finished
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // "Hello, UART!\r\n", byte 0 in the least significant position.
  localparam int MSG_LEN = 14;
  localparam logic [MSG_LEN*8-1:0] MSG_BYTES = {
    8'h0A, 8'h0D, 8'h21, 8'h54, 8'h52, 8'h41, 8'h55,
    8'h20, 8'h2C, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK   // framing error seen: wait for the line to return high
  } rx_state_e;

  // Constant ROM: every address past the message reads as the 0x00 terminator.
  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (int'(a) == i) r = DATA_WIDTH'(MSG_BYTES[i*8 +: 8]);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Byte source
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  is_data_q, is_data_d;

  // Advance only while a real byte is presented, so the terminator is sticky.
  always_comb begin
    addr_d    = addr_q;
    tx_data_d = rom_word(addr_q);
    is_data_d = (rom_word(addr_q) != '0);
    if (next_addr && is_data_q) addr_d = addr_q + ADDR_WIDTH'(1);
  end

  // Source registers; the ROM itself is constant logic and needs no reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      tx_data_q <= '0;
      is_data_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      is_data_q <= is_data_d;
    end
  end

  assign addr          = addr_q;
  assign transmit_data = tx_data_q;
  assign is_data       = is_data_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic rx;

  // Two-flop synchronizer, reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= tx_line;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  busy_q, busy_d;
  logic                  fin_q, fin_d;

  // Receiver next-state: counts cycles to mid-bit and samples there.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    fin_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d = '0;
          if (rx) begin
            state_d = S_IDLE;   // glitch, not a start bit
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_WIDTH-1:1]};   // LSB arrives first
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = S_STOP;
          else                                 bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (rx) begin
            rx_data_d = shift_q;
            fin_d     = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
    end
  end

  assign receive_data = rx_data_q;
  assign is_receiving = busy_q;
  assign is_finished  = fin_q;

endmodule

// File: tb/tb_rom_uart_rx_subsystem.sv
// Self-checking bench for rom_uart_rx_subsystem: ROM walk via a queue of
// expected bytes, UART receive via a scoreboard drained by a monitor.
module tb_rom_uart_rx_subsystem;

  localparam int CPB = 9;

  logic       clk;
  logic       rst_n;
  logic       next_addr;
  logic [4:0] addr;
  logic [7:0] transmit_data;
  logic       is_data;
  logic       tx_line;
  logic [7:0] receive_data;
  logic       is_receiving;
  logic       is_finished;

  int checks;
  int failures;

  logic [7:0] rom_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       prev_fin;

  logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                           8'h55, 8'h41, 8'h52, 8'h54, 8'h21, 8'h0D, 8'h0A};

  rom_uart_rx_subsystem dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_addr     (next_addr),
    .addr          (addr),
    .transmit_data (transmit_data),
    .is_data       (is_data),
    .tx_line       (tx_line),
    .receive_data  (receive_data),
    .is_receiving  (is_receiving),
    .is_finished   (is_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every is_finished must match the oldest expected byte.
  always @(posedge clk) begin
    #1;
    if (prev_fin) check("fin_width", 32'(is_finished), 32'd0);
    if (is_finished && !prev_fin) begin
      if (rx_exp_q.size() == 0) check("rx_spurious", 32'd1, 32'd0);
      else check("rx_byte", 32'(receive_data), 32'(rx_exp_q.pop_front()));
    end
    prev_fin = is_finished;
  end

  task automatic pulse_next();
    @(negedge clk);
    next_addr = 1'b1;
    @(negedge clk);
    next_addr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    tx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      tx_line = b[k];
      repeat (CPB) @(negedge clk);
      if (k == 2) check("rx_busy", 32'(is_receiving), 32'd1);
    end
    tx_line = stop_bit;
    repeat (CPB) @(negedge clk);
    tx_line = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (rx_exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx_drain", 32'(rx_exp_q.size()), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_fin  = 1'b0;
    rst_n     = 1'b0;
    next_addr = 1'b0;
    tx_line   = 1'b1;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_tdata", 32'(transmit_data), 32'd0);
    check("rst_is_data", 32'(is_data), 32'd0);
    check("rst_rdata", 32'(receive_data), 32'd0);
    check("rst_busy", 32'(is_receiving), 32'd0);
    check("rst_fin", 32'(is_finished), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_tdata", 32'(transmit_data), 32'h48);
    check("first_is_data", 32'(is_data), 32'd1);

    // Latency of the first advance: addr moves on the edge, data one edge later.
    @(negedge clk);
    next_addr = 1'b1;
    rom_exp_q.push_back(msg[1]);
    @(posedge clk);
    #1;
    next_addr = 1'b0;
    check("lat_addr", 32'(addr), 32'd1);
    check("lat_tdata_old", 32'(transmit_data), 32'h48);
    @(posedge clk);
    #1;
    check("lat_tdata_new", 32'(transmit_data), 32'(rom_exp_q.pop_front()));

    // Walk the rest of the message.
    for (int i = 2; i < 14; i++) begin
      rom_exp_q.push_back(msg[i]);
      pulse_next();
      repeat (8) @(negedge clk);
      check("walk_tdata", 32'(transmit_data), 32'(rom_exp_q.pop_front()));
      check("walk_is_data", 32'(is_data), 32'd1);
    end
    check("walk_addr", 32'(addr), 32'd13);

    // Onto the terminator, then further pulses are ignored.
    pulse_next();
    repeat (3) @(negedge clk);
    check("term_addr", 32'(addr), 32'd14);
    check("term_is_data", 32'(is_data), 32'd0);
    check("term_tdata", 32'(transmit_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse_next();
      repeat (8) @(negedge clk);
    end
    check("hold_addr", 32'(addr), 32'd14);

    // Single frame
    repeat (5) @(negedge clk);
    rx_exp_q.push_back(8'h48);
    send_frame(8'h48, 1'b1);
    wait_drain();
    check("rx_single_data", 32'(receive_data), 32'h48);

    // Back-to-back frames
    rx_exp_q.push_back(8'h41);
    rx_exp_q.push_back(8'h0A);
    send_frame(8'h41, 1'b1);
    send_frame(8'h0A, 1'b1);
    wait_drain();

    // Short glitch: rejected at the start check.
    repeat (10) @(negedge clk);
    tx_line = 1'b0;
    repeat (2) @(negedge clk);
    tx_line = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(is_receiving), 32'd0);
    check("glitch_rdata", 32'(receive_data), 32'h0A);

    // Framing error: stop bit low, byte discarded.
    send_frame(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy", 32'(is_receiving), 32'd0);
    check("ferr_rdata", 32'(receive_data), 32'h0A);

    // Reset during bit 3 of a frame.
    tx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tx_line = k[0];
      repeat (CPB) @(negedge clk);
    end
    tx_line = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(is_receiving), 32'd0);
    check("mid_rst_rdata", 32'(receive_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    rx_exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain();
    check("post_rst_rdata", 32'(receive_data), 32'h55);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
